// File: rtl/cpu_request_driver.sv
// CPU-side initiator for the cache request/hit port. It queues host commands
// and issues them one at a time, then returns read data and latency per request.
module cpu_request_driver #(
    parameter int CMD_DEPTH      = 4,
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int LAT_W          = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [31:0]      cmd_address,
    input  logic [31:0]      cmd_data,
    input  logic             cmd_wen,
    input  logic [3:0]       cmd_strobe,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [31:0]      rsp_data,
    output logic             rsp_wen,
    output logic [LAT_W-1:0] rsp_latency,
    output logic             reqValid_CPU,
    output logic [31:0]      reqAddress_CPU,
    output logic [31:0]      reqDataIn_CPU,
    output logic             reqWen_CPU,
    output logic [3:0]       reqStrobe_CPU,
    input  logic [31:0]      respDataOut_CPU,
    input  logic             respHit_CPU,
    output logic             busy,
    output logic             timeout_err
);
    localparam int PTR_W   = $clog2(CMD_DEPTH);
    localparam int CNT_W   = $clog2(CMD_DEPTH + 1);
    localparam int WAIT_W  = $clog2(TIMEOUT_CYCLES + 1);
    localparam int ENTRY_W = 69;

    typedef enum logic {
        IDLE,
        WAIT
    } state_t;

    state_t             state;
    logic [ENTRY_W-1:0] fifo_mem [CMD_DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [CNT_W-1:0]   count;
    logic [LAT_W-1:0]   lat_cnt;
    logic [WAIT_W-1:0]  wait_cnt;

    logic               push;
    logic               issue;
    logic               hit;
    logic [ENTRY_W-1:0] head;

    function automatic logic [LAT_W-1:0] sat_inc_lat(input logic [LAT_W-1:0] v);
        return (&v) ? v : v + LAT_W'(1);
    endfunction

    // The wait counter stops at the timeout value so it never wraps back below it.
    function automatic logic [WAIT_W-1:0] sat_inc_wait(input logic [WAIT_W-1:0] v);
        return (v == WAIT_W'(TIMEOUT_CYCLES)) ? v : v + WAIT_W'(1);
    endfunction

    assign cmd_ready = (count != CNT_W'(CMD_DEPTH));
    assign busy      = (count != '0) || (state == WAIT);
    assign push      = cmd_valid && cmd_ready;
    // Issue only when the response slot is free or draining this cycle,
    // so a completion never finds the slot occupied.
    assign issue     = (state == IDLE) && (count != '0) && (!rsp_valid || rsp_ready);
    assign hit       = (state == WAIT) && reqValid_CPU && respHit_CPU;
    assign head      = fifo_mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= {cmd_address, cmd_data, cmd_wen, cmd_strobe};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            count          <= '0;
            lat_cnt        <= '0;
            wait_cnt       <= '0;
            reqValid_CPU   <= 1'b0;
            reqAddress_CPU <= '0;
            reqDataIn_CPU  <= '0;
            reqWen_CPU     <= 1'b0;
            reqStrobe_CPU  <= '0;
            rsp_valid      <= 1'b0;
            rsp_data       <= '0;
            rsp_wen        <= 1'b0;
            rsp_latency    <= '0;
            timeout_err    <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (issue) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, issue})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase

            if (hit) begin
                rsp_valid   <= 1'b1;
                rsp_data    <= reqWen_CPU ? 32'd0 : respDataOut_CPU;
                rsp_wen     <= reqWen_CPU;
                rsp_latency <= lat_cnt;
            end else if (rsp_valid && rsp_ready) begin
                rsp_valid <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (issue) begin
                        state        <= WAIT;
                        reqValid_CPU <= 1'b1;
                        {reqAddress_CPU, reqDataIn_CPU, reqWen_CPU, reqStrobe_CPU} <= head;
                        lat_cnt      <= LAT_W'(1);
                        wait_cnt     <= '0;
                    end
                end
                WAIT: begin
                    if (hit) begin
                        state        <= IDLE;
                        reqValid_CPU <= 1'b0;
                    end else begin
                        lat_cnt  <= sat_inc_lat(lat_cnt);
                        wait_cnt <= sat_inc_wait(wait_cnt);
                        // Flag only; the request keeps waiting for its hit.
                        if (wait_cnt == WAIT_W'(TIMEOUT_CYCLES - 1)) begin
                            timeout_err <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_request_driver.sv
// Bench for cpu_request_driver: directed scenarios and a randomized stream
// checked against a queue-based transaction model of the driver.
module tb_cpu_request_driver;
    localparam int DEPTH   = 4;
    localparam int TMO     = 8;
    localparam int LW      = 4;
    localparam int LAT_MAX = (1 << LW) - 1;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic        wen;
        logic [3:0]  strobe;
    } cmd_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [31:0]   cmd_address;
    logic [31:0]   cmd_data;
    logic          cmd_wen;
    logic [3:0]    cmd_strobe;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [31:0]   rsp_data;
    logic          rsp_wen;
    logic [LW-1:0] rsp_latency;
    logic          reqValid_CPU;
    logic [31:0]   reqAddress_CPU;
    logic [31:0]   reqDataIn_CPU;
    logic          reqWen_CPU;
    logic [3:0]    reqStrobe_CPU;
    logic [31:0]   respDataOut_CPU;
    logic          respHit_CPU;
    logic          busy;
    logic          timeout_err;

    int n_checks = 0;
    int n_pass   = 0;

    cpu_request_driver #(
        .CMD_DEPTH(DEPTH),
        .TIMEOUT_CYCLES(TMO),
        .LAT_W(LW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_address(cmd_address),
        .cmd_data(cmd_data),
        .cmd_wen(cmd_wen),
        .cmd_strobe(cmd_strobe),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_data(rsp_data),
        .rsp_wen(rsp_wen),
        .rsp_latency(rsp_latency),
        .reqValid_CPU(reqValid_CPU),
        .reqAddress_CPU(reqAddress_CPU),
        .reqDataIn_CPU(reqDataIn_CPU),
        .reqWen_CPU(reqWen_CPU),
        .reqStrobe_CPU(reqStrobe_CPU),
        .respDataOut_CPU(respDataOut_CPU),
        .respHit_CPU(respHit_CPU),
        .busy(busy),
        .timeout_err(timeout_err)
    );

    initial forever #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_cmd(input cmd_t c);
        cmd_address = c.addr;
        cmd_data    = c.data;
        cmd_wen     = c.wen;
        cmd_strobe  = c.strobe;
    endtask

    task automatic drive_idle();
        cmd_valid       = 1'b0;
        cmd_address     = '0;
        cmd_data        = '0;
        cmd_wen         = 1'b0;
        cmd_strobe      = '0;
        rsp_ready       = 1'b0;
        respHit_CPU     = 1'b0;
        respDataOut_CPU = '0;
    endtask

    task automatic do_reset();
        drive_idle();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        drive_idle();
        rst = 1'b1;
        cmd_valid = 1'b1;
        cmd_address = 32'h0000_0080;
        tick();
        tick();
        tick();
        n_checks++; if (cmd_ready !== 1'b1) $display("FAIL reset_cmd_ready: got %b expected 1", cmd_ready); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy); else n_pass++;
        n_checks++; if (reqValid_CPU !== 1'b0) $display("FAIL reset_reqValid: got %b expected 0", reqValid_CPU); else n_pass++;
        n_checks++; if (rsp_valid !== 1'b0) $display("FAIL reset_rsp_valid: got %b expected 0", rsp_valid); else n_pass++;
        n_checks++; if (timeout_err !== 1'b0) $display("FAIL reset_timeout: got %b expected 0", timeout_err); else n_pass++;
        n_checks++; if ({rsp_data, rsp_wen, rsp_latency} !== '0) $display("FAIL reset_rsp_bus: got %h/%b/%0d expected zeros", rsp_data, rsp_wen, rsp_latency); else n_pass++;
        n_checks++; if ({reqAddress_CPU, reqDataIn_CPU, reqWen_CPU, reqStrobe_CPU} !== '0) $display("FAIL reset_req_bus: got %h/%h expected zeros", reqAddress_CPU, reqDataIn_CPU); else n_pass++;
        rst = 1'b0;
        cmd_valid = 1'b0;
        tick();
        n_checks++; if (busy !== 1'b0) $display("FAIL reset_no_push: busy got %b expected 0", busy); else n_pass++;
        tick();
        n_checks++; if (reqValid_CPU !== 1'b0) $display("FAIL reset_no_issue: reqValid got %b expected 0", reqValid_CPU); else n_pass++;
    endtask

    task automatic test_single_read();
        cmd_t c;
        do_reset();
        c = '{addr: 32'h0000_0040, data: 32'h55AA_55AA, wen: 1'b0, strobe: 4'h0};
        drive_cmd(c);
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        n_checks++; if (reqValid_CPU !== 1'b0 || busy !== 1'b1) $display("FAIL read_queued: reqValid/busy got %b/%b expected 0/1", reqValid_CPU, busy); else n_pass++;
        tick();
        n_checks++; if (reqValid_CPU !== 1'b1) $display("FAIL read_issue: reqValid got %b expected 1", reqValid_CPU); else n_pass++;
        n_checks++; if ({reqAddress_CPU, reqDataIn_CPU, reqWen_CPU, reqStrobe_CPU} !== c) $display("FAIL read_req_bus: got %h/%h expected %h/%h", reqAddress_CPU, reqDataIn_CPU, c.addr, c.data); else n_pass++;
        respHit_CPU = 1'b1;
        respDataOut_CPU = 32'hDEAD_BEEF;
        tick();
        respHit_CPU = 1'b0;
        respDataOut_CPU = '0;
        n_checks++; if (rsp_valid !== 1'b1) $display("FAIL read_rsp_valid: got %b expected 1", rsp_valid); else n_pass++;
        n_checks++; if (rsp_data !== 32'hDEAD_BEEF) $display("FAIL read_rsp_data: got %h expected deadbeef", rsp_data); else n_pass++;
        n_checks++; if (rsp_wen !== 1'b0) $display("FAIL read_rsp_wen: got %b expected 0", rsp_wen); else n_pass++;
        n_checks++; if (rsp_latency !== LW'(1)) $display("FAIL read_latency: got %0d expected 1", rsp_latency); else n_pass++;
        n_checks++; if (reqValid_CPU !== 1'b0 || busy !== 1'b0) $display("FAIL read_done: reqValid/busy got %b/%b expected 0/0", reqValid_CPU, busy); else n_pass++;
        tick();
        n_checks++; if (rsp_valid !== 1'b1) $display("FAIL read_rsp_hold: got %b expected 1", rsp_valid); else n_pass++;
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        n_checks++; if (rsp_valid !== 1'b0) $display("FAIL read_rsp_drain: got %b expected 0", rsp_valid); else n_pass++;
    endtask

    task automatic test_miss_latency();
        cmd_t c;
        int unstable;
        do_reset();
        c = '{addr: 32'h0000_0100, data: 32'h1234_5678, wen: 1'b1, strobe: 4'hF};
        drive_cmd(c);
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        tick();
        unstable = 0;
        for (int i = 1; i <= 9; i++) begin
            if (reqValid_CPU !== 1'b1 || {reqAddress_CPU, reqDataIn_CPU, reqWen_CPU, reqStrobe_CPU} !== c) unstable++;
            tick();
            if (i == TMO - 1) begin
                n_checks++; if (timeout_err !== 1'b0) $display("FAIL miss_timeout_early: got %b expected 0", timeout_err); else n_pass++;
            end
            if (i == TMO) begin
                n_checks++; if (timeout_err !== 1'b1) $display("FAIL miss_timeout_set: got %b expected 1", timeout_err); else n_pass++;
            end
        end
        if (reqValid_CPU !== 1'b1 || {reqAddress_CPU, reqDataIn_CPU, reqWen_CPU, reqStrobe_CPU} !== c) unstable++;
        n_checks++; if (unstable !== 0) $display("FAIL miss_req_stable: unstable cycles got %0d expected 0", unstable); else n_pass++;
        respHit_CPU = 1'b1;
        respDataOut_CPU = 32'hCAFE_F00D;
        tick();
        respHit_CPU = 1'b0;
        n_checks++; if (rsp_valid !== 1'b1) $display("FAIL miss_rsp_valid: got %b expected 1", rsp_valid); else n_pass++;
        n_checks++; if (rsp_latency !== LW'(10)) $display("FAIL miss_latency: got %0d expected 10", rsp_latency); else n_pass++;
        n_checks++; if (rsp_data !== 32'd0) $display("FAIL miss_write_data: got %h expected 0", rsp_data); else n_pass++;
        n_checks++; if (rsp_wen !== 1'b1) $display("FAIL miss_rsp_wen: got %b expected 1", rsp_wen); else n_pass++;
        n_checks++; if (reqValid_CPU !== 1'b0) $display("FAIL miss_req_drop: got %b expected 0", reqValid_CPU); else n_pass++;
    endtask

    task automatic test_backpressure();
        cmd_t cmds [6];
        logic [31:0] rd;
        int refused, stall_issue, misses;
        do_reset();
        for (int i = 0; i < 6; i++) begin
            cmds[i].addr   = 32'h0000_1000 + 32'(i * 4);
            cmds[i].data   = $urandom();
            cmds[i].wen    = 1'(i % 2);
            cmds[i].strobe = 4'($urandom());
        end
        refused = 0;
        for (int i = 0; i < 5; i++) begin
            drive_cmd(cmds[i]);
            cmd_valid = 1'b1;
            if (cmd_ready !== 1'b1) refused++;
            tick();
        end
        n_checks++; if (refused !== 0) $display("FAIL bp_pushes_refused: got %0d expected 0", refused); else n_pass++;
        n_checks++; if (cmd_ready !== 1'b0) $display("FAIL bp_full: cmd_ready got %b expected 0", cmd_ready); else n_pass++;
        n_checks++; if (reqValid_CPU !== 1'b1 || reqAddress_CPU !== cmds[0].addr) $display("FAIL bp_first_issue: got %b/%h expected 1/%h", reqValid_CPU, reqAddress_CPU, cmds[0].addr); else n_pass++;
        drive_cmd(cmds[5]);
        tick();
        tick();
        n_checks++; if (cmd_ready !== 1'b0) $display("FAIL bp_still_full: cmd_ready got %b expected 0", cmd_ready); else n_pass++;
        cmd_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (i > 0) begin
                rsp_ready = 1'b1;
                tick();
                rsp_ready = 1'b0;
                n_checks++; if (rsp_valid !== 1'b0) $display("FAIL bp_drain_%0d: rsp_valid got %b expected 0", i, rsp_valid); else n_pass++;
                n_checks++; if (reqValid_CPU !== 1'b1 || {reqAddress_CPU, reqDataIn_CPU, reqWen_CPU, reqStrobe_CPU} !== cmds[i]) $display("FAIL bp_issue_%0d: got %b/%h expected 1/%h", i, reqValid_CPU, reqAddress_CPU, cmds[i].addr); else n_pass++;
                if (i == 1) begin
                    n_checks++; if (cmd_ready !== 1'b1) $display("FAIL bp_ready_back: got %b expected 1", cmd_ready); else n_pass++;
                end
                misses = $urandom_range(0, 3);
                for (int m = 0; m < misses; m++) tick();
            end
            rd = $urandom();
            respHit_CPU = 1'b1;
            respDataOut_CPU = rd;
            tick();
            respHit_CPU = 1'b0;
            n_checks++; if (reqValid_CPU !== 1'b0) $display("FAIL bp_gap_%0d: reqValid got %b expected 0", i, reqValid_CPU); else n_pass++;
            n_checks++; if (rsp_valid !== 1'b1 || rsp_wen !== cmds[i].wen || rsp_data !== (cmds[i].wen ? 32'd0 : rd)) $display("FAIL bp_rsp_%0d: got %b/%b/%h expected 1/%b/%h", i, rsp_valid, rsp_wen, rsp_data, cmds[i].wen, cmds[i].wen ? 32'd0 : rd); else n_pass++;
            if (i == 0) begin
                stall_issue = 0;
                for (int s = 0; s < 3; s++) begin
                    tick();
                    if (reqValid_CPU !== 1'b0) stall_issue++;
                end
                n_checks++; if (stall_issue !== 0) $display("FAIL bp_stall: issue cycles got %0d expected 0", stall_issue); else n_pass++;
                n_checks++; if (rsp_valid !== 1'b1) $display("FAIL bp_stall_hold: rsp_valid got %b expected 1", rsp_valid); else n_pass++;
            end
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        tick();
        tick();
        n_checks++; if (rsp_valid !== 1'b0 || reqValid_CPU !== 1'b0 || busy !== 1'b0) $display("FAIL bp_final_idle: rsp_valid/reqValid/busy got %b/%b/%b expected 0/0/0", rsp_valid, reqValid_CPU, busy); else n_pass++;
    endtask

    task automatic test_timeout_saturation();
        cmd_t c;
        do_reset();
        c = '{addr: 32'h0000_0200, data: 32'hA5A5_0000, wen: 1'b0, strobe: 4'h3};
        drive_cmd(c);
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        tick();
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (i == TMO - 1) begin
                n_checks++; if (timeout_err !== 1'b0) $display("FAIL tmo_before: got %b expected 0", timeout_err); else n_pass++;
            end
            if (i == TMO) begin
                n_checks++; if (timeout_err !== 1'b1) $display("FAIL tmo_set: got %b expected 1", timeout_err); else n_pass++;
                n_checks++; if (reqValid_CPU !== 1'b1) $display("FAIL tmo_not_aborted: reqValid got %b expected 1", reqValid_CPU); else n_pass++;
            end
        end
        respHit_CPU = 1'b1;
        respDataOut_CPU = 32'h0BAD_F00D;
        tick();
        respHit_CPU = 1'b0;
        n_checks++; if (rsp_valid !== 1'b1 || rsp_data !== 32'h0BAD_F00D) $display("FAIL tmo_complete: got %b/%h expected 1/0badf00d", rsp_valid, rsp_data); else n_pass++;
        n_checks++; if (rsp_latency !== LW'(LAT_MAX)) $display("FAIL lat_saturate: got %0d expected %0d", rsp_latency, LAT_MAX); else n_pass++;
        n_checks++; if (timeout_err !== 1'b1) $display("FAIL tmo_sticky: got %b expected 1", timeout_err); else n_pass++;
    endtask

    task automatic test_random();
        cmd_t q[$];
        cmd_t cur, c;
        bit inflight, m_rv, m_to, m_rw, drain, push, issue, hit;
        logic [31:0] m_rd;
        int m_rl, lat, waitc, miss_left;
        inflight = 0; m_rv = 0; m_to = 0; m_rw = 0; m_rd = '0; m_rl = 0;
        lat = 0; waitc = 0; miss_left = 0; cur = '0;
        do_reset();
        for (int cyc = 0; cyc < 600; cyc++) begin
            drain = (cyc >= 450);
            c.addr = $urandom(); c.data = $urandom();
            c.wen = 1'($urandom_range(0, 1)); c.strobe = 4'($urandom());
            drive_cmd(c);
            cmd_valid = !drain && ($urandom_range(0, 2) != 0);
            rsp_ready = drain ? 1'b1 : ($urandom_range(0, 3) == 0);
            respDataOut_CPU = $urandom();
            respHit_CPU = inflight ? (miss_left == 0) : ($urandom_range(0, 3) == 0);

            push  = cmd_valid && (q.size() < DEPTH);
            issue = !inflight && (q.size() > 0) && (!m_rv || rsp_ready);
            hit   = inflight && respHit_CPU;
            if (hit) begin
                m_rv = 1; m_rw = cur.wen; m_rl = lat;
                m_rd = cur.wen ? 32'd0 : respDataOut_CPU;
                inflight = 0;
            end else if (m_rv && rsp_ready) begin
                m_rv = 0;
            end
            if (inflight) begin
                lat = (lat < LAT_MAX) ? lat + 1 : lat;
                waitc++;
                if (waitc == TMO) m_to = 1;
                miss_left--;
            end
            if (issue) begin
                cur = q.pop_front();
                inflight = 1; lat = 1; waitc = 0;
                miss_left = ($urandom_range(0, 9) == 0) ? int'($urandom_range(8, 12)) : int'($urandom_range(0, 3));
            end
            if (push) q.push_back(c);

            tick();
            n_checks++; if (cmd_ready !== (q.size() < DEPTH)) $display("FAIL rnd_cmd_ready @%0d: got %b expected %b", cyc, cmd_ready, q.size() < DEPTH); else n_pass++;
            n_checks++; if (busy !== (q.size() != 0 || inflight)) $display("FAIL rnd_busy @%0d: got %b expected %b", cyc, busy, q.size() != 0 || inflight); else n_pass++;
            n_checks++; if (reqValid_CPU !== inflight) $display("FAIL rnd_reqValid @%0d: got %b expected %b", cyc, reqValid_CPU, inflight); else n_pass++;
            if (inflight) begin
                n_checks++; if ({reqAddress_CPU, reqDataIn_CPU, reqWen_CPU, reqStrobe_CPU} !== cur) $display("FAIL rnd_req_bus @%0d: got %h/%h expected %h/%h", cyc, reqAddress_CPU, reqDataIn_CPU, cur.addr, cur.data); else n_pass++;
            end
            n_checks++; if (rsp_valid !== m_rv) $display("FAIL rnd_rsp_valid @%0d: got %b expected %b", cyc, rsp_valid, m_rv); else n_pass++;
            if (m_rv) begin
                n_checks++; if (rsp_data !== m_rd || rsp_wen !== m_rw || rsp_latency !== LW'(m_rl)) $display("FAIL rnd_rsp @%0d: got %h/%b/%0d expected %h/%b/%0d", cyc, rsp_data, rsp_wen, rsp_latency, m_rd, m_rw, m_rl); else n_pass++;
            end
            n_checks++; if (timeout_err !== m_to) $display("FAIL rnd_timeout @%0d: got %b expected %b", cyc, timeout_err, m_to); else n_pass++;
        end
        n_checks++; if (q.size() !== 0 || busy !== 1'b0) $display("FAIL rnd_drained: model queue %0d busy %b expected 0/0", q.size(), busy); else n_pass++;
        drive_idle();
    endtask

    task automatic test_reset_mid();
        cmd_t c;
        int stray;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            c = '{addr: 32'h0000_3000 + 32'(i * 16), data: $urandom(), wen: 1'b0, strobe: 4'hF};
            drive_cmd(c);
            cmd_valid = 1'b1;
            tick();
        end
        cmd_valid = 1'b0;
        n_checks++; if (reqValid_CPU !== 1'b1 || busy !== 1'b1 || cmd_ready !== 1'b1) $display("FAIL mid_setup: reqValid/busy/ready got %b/%b/%b expected 1/1/1", reqValid_CPU, busy, cmd_ready); else n_pass++;
        for (int i = 0; i < TMO; i++) tick();
        n_checks++; if (timeout_err !== 1'b1) $display("FAIL mid_timeout_pre: got %b expected 1", timeout_err); else n_pass++;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_checks++; if (reqValid_CPU !== 1'b0) $display("FAIL mid_reqValid: got %b expected 0", reqValid_CPU); else n_pass++;
        n_checks++; if (busy !== 1'b0 || cmd_ready !== 1'b1) $display("FAIL mid_fifo_empty: busy/ready got %b/%b expected 0/1", busy, cmd_ready); else n_pass++;
        n_checks++; if (rsp_valid !== 1'b0) $display("FAIL mid_rsp_valid: got %b expected 0", rsp_valid); else n_pass++;
        n_checks++; if (timeout_err !== 1'b0) $display("FAIL mid_timeout_clear: got %b expected 0", timeout_err); else n_pass++;
        stray = 0;
        respHit_CPU = 1'b1;
        respDataOut_CPU = 32'h1111_2222;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (rsp_valid !== 1'b0 || reqValid_CPU !== 1'b0) stray++;
        end
        respHit_CPU = 1'b0;
        n_checks++; if (stray !== 0) $display("FAIL mid_no_response: stray cycles got %0d expected 0", stray); else n_pass++;
    endtask

    initial begin
        drive_idle();
        rst = 1'b0;
        test_reset();
        test_single_read();
        test_miss_latency();
        test_backpressure();
        test_timeout_saturation();
        test_random();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/cpu_request_driver.md
Name: cpu_request_driver

Overview:
- CPU-side initiator for the MemorySystem request/hit interface.
- Accepts commands (address, data, write-enable, strobe) from a host or testbench through a valid/ready queue.
- Issues them one at a time to the cache's CPU port and holds each request stable until the cache signals hit.
- Returns the completion (read data and latency) through a valid/ready response port, and flags requests that exceed a timeout.

Parameters:
- CMD_DEPTH, 4: command FIFO entries; power of two, ≥2.
- TIMEOUT_CYCLES, 1024: wait-cycle count at which timeout_err sets; must be ≥2.
- LAT_W, 16: latency counter width; the counter saturates.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- cmd_valid  in  1  host command valid
- cmd_ready  out  1  FIFO not full
- cmd_address  in  32  byte address
- cmd_data  in  32  write data
- cmd_wen  in  1  1=write, 0=read
- cmd_strobe  in  4  byte enables (writes)
- rsp_valid  out  1  completion valid
- rsp_ready  in  1  host accepts completion
- rsp_data  out  32  read data (0 for writes)
- rsp_wen  out  1  echo of command wen
- rsp_latency  out  LAT_W  cycles reqValid_CPU was high for this request, including the hit cycle
- reqValid_CPU  out  1  request valid to cache
- reqAddress_CPU  out  32  request address
- reqDataIn_CPU  out  32  request write data
- reqWen_CPU  out  1  request write enable
- reqStrobe_CPU  out  4  request strobe
- respDataOut_CPU  in  32  cache read data, valid in the hit cycle
- respHit_CPU  in  1  request complete this cycle
- busy  out  1  FIFO non-empty or request in flight
- timeout_err  out  1  sticky; cleared only by rst

Behaviour:
- Reset (rst=1 at a clock edge):
  - FIFO empties; FSM goes to IDLE.
  - All outputs go to 0: reqValid_CPU, req* buses, rsp_valid, rsp_data, rsp_wen, rsp_latency, busy, timeout_err.
  - cmd_ready is 1 after reset.
  - Reset mid-request drops reqValid_CPU on the next edge; that request is discarded and produces no response.
- Command FIFO:
  - Push on cmd_valid & cmd_ready. cmd_ready = !full.
  - Pop only on an IDLE→WAIT transition.
  - Push and pop in the same cycle when full: the push is refused, because cmd_ready is already 0.
  - Pointers wrap modulo CMD_DEPTH. A count register distinguishes full from empty.
- FSM states: IDLE and WAIT.
- IDLE:
  - Go to WAIT when the FIFO is non-empty AND (rsp_valid==0 OR rsp_ready==1).
  - On that transition, register the FIFO head onto req* and set reqValid_CPU=1 on the next cycle.
  - Load the latency counter with 1 and clear the wait counter.
- WAIT:
  - req* and reqValid_CPU hold constant.
  - The latency counter increments each cycle that respHit_CPU==0 and saturates at 2^LAT_W-1.
  - When respHit_CPU==1 (which may occur in the first WAIT cycle):
    - Capture rsp_data = reqWen_CPU ? 0 : respDataOut_CPU.
    - Capture rsp_wen and rsp_latency; set rsp_valid=1.
    - Drop reqValid_CPU; return to IDLE.
  - respHit_CPU is ignored whenever reqValid_CPU==0.
- Back-to-back issue:
  - The earliest next issue is the cycle after the hit cycle, so reqValid_CPU is low for ≥1 cycle between requests.
  - The next issue happens then only if the host drains rsp (rsp_ready=1 that cycle).
- Response slot:
  - rsp_valid clears on rsp_valid & rsp_ready unless a new completion loads in the same cycle.
  - The slot is guaranteed empty during WAIT by the IDLE issue rule.
- Timeout:
  - The wait counter counts WAIT cycles without a hit.
  - When it reaches TIMEOUT_CYCLES, timeout_err sets (sticky).
  - The request is NOT aborted; the driver keeps waiting for the hit.
- busy = (count!=0) | (state==WAIT).
- Writes: the cache ignores reqDataIn_CPU/reqStrobe_CPU on reads; the driver forwards them unmodified regardless.

Test Plan:
- Reset check: hold rst with cmd_valid=1 → no push; after release cmd_ready=1, reqValid_CPU=0, rsp_valid=0, busy=0.
- Single read, hit in first WAIT cycle: push read 0x0000_0040; cache returns respHit_CPU=1, data 0xDEAD_BEEF in the first valid cycle → rsp_valid=1, rsp_data=0xDEAD_BEEF, rsp_wen=0, rsp_latency=1.
- Miss latency: push write 0x100, data 0x1234_5678, strobe 0xF; hit after 9 cycles of reqValid_CPU → rsp_latency=10, rsp_data=0, rsp_wen=1; req* stable throughout.
- FIFO full / backpressure:
  - Push 5 commands with rsp_ready=0 → cmd_ready=0 after 4 are queued.
  - One completion occurs; issue stalls until rsp_ready=1.
  - All 5 then complete in order; reqValid_CPU is low ≥1 cycle between requests.
- Timeout: TIMEOUT_CYCLES=8, withhold hit → timeout_err=1 after 8 WAIT cycles; reqValid_CPU stays 1; a later hit completes normally with timeout_err still 1.
- Reset mid-request: assert rst while in WAIT with 2 queued → next cycle reqValid_CPU=0, FIFO empty, no rsp_valid, timeout_err=0.
